// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, the
// NOP substituted for faulted fetches, the default timeout and a small
// alignment helper.
package fetch_pkg;

  // FSM state encodings (plain constants for compatibility with older tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef logic [1:0] fetch_state_t;

  // Word presented to decode when a fetch faults
  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  // Default number of request cycles tolerated without an acknowledge
  localparam int DEFAULT_TIMEOUT = 15;

  // A fetch address is word-aligned only when its two low bits are zero
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating request-cycle counter for the fetch stage. It is cleared when a
// new memory request starts, counts every cycle the request stays open and
// flags the last cycle that may still be waited on.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Clear on load, otherwise count open request cycles and hold at TIMEOUT
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CNT_W'(0);
    end else if (load) begin
      count <= CNT_W'(0);
    end else if (enable && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // The current cycle is the TIMEOUT-th one the request has been open
  assign expired = (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage sitting right after the PC register. Each PC is
// either served from a one-entry last-fetch buffer, turned into a fault NOP
// when misaligned, or fetched from instruction memory over a req/ack
// handshake. The held instruction is offered to decode with Instr_Valid and
// Stall freezes the PC register until decode consumes it or a Flush arrives.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Flush,
  input  logic              Consume,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] Instr,
  output logic              Instr_Valid,
  output logic              Fetch_Fault,
  output logic              Stall
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;

  // Last-fetch buffer: address tag plus the word read from that address
  logic [ADDR_W-1:0] tag;
  logic [ADDR_W-1:0] tag_nxt;
  logic              tag_valid;
  logic              tag_valid_nxt;
  logic [DATA_W-1:0] buffer;
  logic [DATA_W-1:0] buffer_nxt;

  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              valid_nxt;
  logic              fault_nxt;

  logic              ctr_load;
  logic              ctr_en;
  logic              ctr_expired;
  logic              buf_hit;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (Reset),
    .load    (ctr_load),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  assign buf_hit = tag_valid && (PC == tag);

  // The PC register may load on a redirect or when decode takes the held word
  assign Stall = !Flush && !((state == ST_HOLD) && Consume);

  // Next-state and next-output decode for the fetch FSM
  always_comb begin
    state_nxt     = state;
    req_nxt       = imem_req;
    addr_nxt      = imem_addr;
    instr_nxt     = Instr;
    valid_nxt     = Instr_Valid;
    fault_nxt     = Fetch_Fault;
    tag_nxt       = tag;
    tag_valid_nxt = tag_valid;
    buffer_nxt    = buffer;
    ctr_load      = 1'b0;
    ctr_en        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Flush) begin
          // PC is being redirected this cycle; sample the new one next cycle
          state_nxt = ST_IDLE;
        end else if (is_misaligned(PC[1:0])) begin
          instr_nxt = DATA_W'(FETCH_NOP);
          fault_nxt = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end else if (buf_hit) begin
          instr_nxt = buffer;
          fault_nxt = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          addr_nxt  = PC;
          req_nxt   = 1'b1;
          ctr_load  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        ctr_en = 1'b1;
        if (imem_ack) begin
          // Data is always captured, even when a Flush discards the slot
          instr_nxt     = imem_rdata;
          tag_nxt       = imem_addr;
          tag_valid_nxt = 1'b1;
          buffer_nxt    = imem_rdata;
          fault_nxt     = 1'b0;
          req_nxt       = 1'b0;
          if (Flush) begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            valid_nxt = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (ctr_expired) begin
          // Abandon the request outright; the memory tolerates that
          req_nxt = 1'b0;
          if (Flush) begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            instr_nxt = DATA_W'(FETCH_NOP);
            fault_nxt = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (Flush) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_WAIT;
        end
      end

      ST_DRAIN: begin
        // Keep the flushed request open until it completes or times out
        ctr_en = 1'b1;
        if (imem_ack || ctr_expired) begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (Consume || Flush) begin
          valid_nxt = 1'b0;
          fault_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_HOLD;
        end
      end

      default: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
        fault_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, outputs and last-fetch buffer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= {ADDR_W{1'b0}};
      Instr       <= {DATA_W{1'b0}};
      Instr_Valid <= 1'b0;
      Fetch_Fault <= 1'b0;
      tag         <= {ADDR_W{1'b0}};
      tag_valid   <= 1'b0;
      buffer      <= {DATA_W{1'b0}};
    end else begin
      state       <= state_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      Instr       <= instr_nxt;
      Instr_Valid <= valid_nxt;
      Fetch_Fault <= fault_nxt;
      tag         <= tag_nxt;
      tag_valid   <= tag_valid_nxt;
      buffer      <= buffer_nxt;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage directly downstream of the PC register. It samples `PC`, fetches the word from a variable-latency instruction memory over a req/ack handshake and presents it to decode with a valid flag. It raises `Stall` to freeze the PC register until decode consumes the instruction. A one-entry last-fetch buffer returns a repeated PC without a memory access, and alignment and timeout faults turn the slot into a NOP.

## Interface
- `ADDR_W`, 32, PC/memory address width
- `DATA_W`, 32, instruction width
- `TIMEOUT`, 15, maximum WAIT cycles without `imem_ack` before a fault
- `clk` in 1: clock
- `Reset` in 1: synchronous, active-high reset
- `PC` in ADDR_W: current PC from the PC register
- `Flush` in 1: redirect; abandon the current fetch or held instruction
- `Consume` in 1: decode accepts `Instr` this cycle
- `imem_req` out 1: memory read request, held until ack
- `imem_addr` out ADDR_W: request address, stable while `imem_req`
- `imem_ack` in 1: memory read complete; `imem_rdata` valid
- `imem_rdata` in DATA_W: read data
- `Instr` out DATA_W: fetched instruction
- `Instr_Valid` out 1: `Instr` is valid for decode
- `Fetch_Fault` out 1: held instruction is a fault NOP
- `Stall` out 1: PC register must not load this cycle

## Operation
- States: IDLE, WAIT, HOLD, DRAIN.
- IDLE transitions:
  - `PC[1:0]` != 0: `Instr` <= 0 and `Fetch_Fault` <= 1, then HOLD.
  - Else if `tag_valid` and `PC == tag`: `Instr` <= buffered word, then HOLD (no memory access).
  - Else: `imem_addr` <= `PC`, counter <= 0, then WAIT.
- WAIT: `imem_req`=1.
  - On `imem_ack`: `Instr` <= `imem_rdata`, `tag` <= `imem_addr`, `tag_valid` <= 1, buffer <= `imem_rdata`, `Fetch_Fault` <= 0, then HOLD.
  - Counter == `TIMEOUT`-1 without ack: `Instr` <= 0 and `Fetch_Fault` <= 1, then DRAIN.
  - `Flush` without ack: DRAIN.
- DRAIN: `imem_req`=1 until `imem_ack`, data discarded, then IDLE. Counter continues; reaching `TIMEOUT` also returns to IDLE. A timeout-fault HOLD is deferred: after the drain completes, the fault is presented in HOLD.
  - Simplification to be implemented: a timeout in WAIT goes to HOLD with the fault and deasserts `imem_req`. The memory must tolerate an abandoned request. No DRAIN on timeout.
- HOLD: `Instr_Valid`=1.
  - `Consume` or `Flush`: IDLE, and `Instr_Valid`/`Fetch_Fault` clear next cycle.
- `Stall` = !`Flush` && !(state==HOLD && `Consume`).
- Simultaneous events:
  - ack with `Flush` in WAIT: ack wins the capture, but `Flush` forces IDLE.
  - ack on the timeout cycle: ack wins.
  - ack outside WAIT/DRAIN: ignored.
- `Flush` never invalidates the tag (instruction memory is read-only).

## Timing
- Reset (next edge): state IDLE; `imem_req`=0, `imem_addr`=0, `Instr`=0, `Instr_Valid`=0, `Fetch_Fault`=0, `Stall`=1, `tag_valid`=0.
- Reset mid-WAIT drops `imem_req` at that edge.
- Memory miss, zero-wait memory: PC sampled in IDLE at cycle n; `imem_req` at n+1 with ack; `Instr_Valid` at n+2; `Consume` at n+2 lets the PC load; IDLE at n+3. Throughput is 3 cycles per instruction.
- Buffer hit or alignment fault: `Instr_Valid` one cycle after IDLE. Throughput is 2 cycles per instruction.
- Memory latency L cycles of ack delay adds L cycles.
- Timeout: fault after exactly `TIMEOUT` cycles of `imem_req` high without ack.
- Counter width is clog2(`TIMEOUT`+1) and saturates; there is no wrap.
- `imem_addr` and `imem_req` are registered and change only on state transitions.

## Structure
- `fetch_pkg`:
  - state enum (IDLE/WAIT/HOLD/DRAIN)
  - `FETCH_NOP` = 32'h0000_0000
  - default `TIMEOUT`
- One sub-module, `fetch_timeout_ctr`: load/enable/saturating counter with `expired` output, parameterised by `TIMEOUT`.
- Everything else is flat in `instr_fetch`.

## Test plan
- Reset, then `PC`=0x0, memory acks in the same cycle with 0x2002_0005 → `imem_req` for 1 cycle at addr 0x0; `Instr`=0x2002_0005 and `Instr_Valid`=1 two cycles after IDLE; `Stall`=0 only on the `Consume` cycle.
- `PC` held at 0x40 after a completed fetch of 0x40 (loop) → no `imem_req`; `Instr_Valid` next cycle with the buffered word.
- `PC`=0x42 → no request; `Instr_Valid`=1, `Fetch_Fault`=1, `Instr`=0.
- Memory never acks, `TIMEOUT`=15 → `imem_req` high exactly 15 cycles; then `Fetch_Fault`=1 and `Instr`=0 in HOLD.
- `Flush` in WAIT, ack 3 cycles later with 0xDEAD_BEEF → `imem_req` held through the ack; data not presented; returns to IDLE; new PC fetched; `Stall`=0 on the `Flush` cycle.
- `Reset` asserted during WAIT → `imem_req`=0, `Instr_Valid`=0 and `tag_valid`=0 after the edge; the same PC is refetched from memory.
